aurora_tx_pktfifo: RTL and testbench

- Store-and-forward packet FIFO directly downstream of aurora_axi_tx_mux, feeding the Aurora TX user interface.
- Accepts the mux's 32-bit AXI-Stream output and releases a frame only once its tlast has been stored, so Aurora TX never sees an intra-frame underrun gap.
- A frame that overflows the buffer is dropped whole and counted.

---
 rtl/aurora_tx_pkg.sv | 21 ++
 rtl/aurora_tx_pktfifo_ram.sv | 33 +++
 rtl/aurora_tx_pktfifo.sv | 177 +++++++++++++++++
 tb/tb_aurora_tx_pktfifo.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_tx_pkg.sv
// Shared definitions for the Aurora TX store-and-forward packet FIFO.
// Provides the stored RAM word layout and the write-side FSM encoding.
package aurora_tx_pkg;

    localparam int RAM_W     = 37;
    localparam int TLAST_BIT = 36;
    localparam int TKEEP_LSB = 32;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_STORE = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_e;

    function automatic logic [RAM_W-1:0] pack_word(input logic        last,
                                                   input logic [3:0]  keep,
                                                   input logic [31:0] data);
        return {last, keep, data};
    endfunction

endpackage

// File: rtl/aurora_tx_pktfifo_ram.sv
// Simple dual-port RAM for the packet FIFO: synchronous write, registered
// read with read enable (the output register holds when rd_en=0).
// Ports:
//   clk              clock
//   wr_en/addr/data  write port
//   rd_en/addr       read request, data appears on rd_data one clock later
//   rd_data          registered read data
module aurora_tx_pktfifo_ram
    import aurora_tx_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int WIDTH  = RAM_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/aurora_tx_pktfifo.sv
// Store-and-forward packet FIFO between aurora_axi_tx_mux and the Aurora TX
// user interface. A frame becomes visible to the read side only after its
// tlast is stored; a frame that does not fit is dropped whole and counted.
// Ports:
//   clk, rst                 clock, async active-high reset
//   axis_s_*                 32-bit AXI-Stream input from the mux
//   axis_m_*                 32-bit AXI-Stream output to Aurora TX (registered)
//   stat_frames              frames forwarded (wraps)
//   stat_drops               frames dropped (saturates)
//   level                    committed words not yet delivered
//
// Write FSM:
//   state    | meaning
//   WR_IDLE  | between frames, waiting for first beat
//   WR_STORE | frame in progress, beats written to RAM
//   WR_DROP  | frame overflowed, discarding beats until tlast
module aurora_tx_pktfifo
    import aurora_tx_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int FRAME_CNT_W = 5,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              axis_s_tready,
    input  logic [31:0]       axis_s_tdata,
    input  logic [3:0]        axis_s_tkeep,
    input  logic              axis_s_tvalid,
    input  logic              axis_s_tlast,
    input  logic              axis_m_tready,
    output logic [31:0]       axis_m_tdata,
    output logic [3:0]        axis_m_tkeep,
    output logic              axis_m_tvalid,
    output logic              axis_m_tlast,
    output logic [STAT_W-1:0] stat_frames,
    output logic [STAT_W-1:0] stat_drops,
    output logic [ADDR_W:0]   level
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0]       PTR_ONE    = PTR_W'(1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_ONE  = FRAME_CNT_W'(1);
    localparam logic [FRAME_CNT_W-1:0] FRAMES_MAX = '1;
    localparam logic [STAT_W-1:0]      STAT_ONE   = STAT_W'(1);
    localparam logic [STAT_W-1:0]      STAT_MAX   = '1;

    wr_state_e              state, state_nxt;
    logic                   run;
    logic [PTR_W-1:0]       wr_ptr, wr_ptr_inc, wr_commit, commit_q;
    logic [PTR_W-1:0]       fetch_ptr, rd_ptr;
    logic [FRAME_CNT_W-1:0] frames_stored;
    logic                   accept, full, wr_en, do_commit, do_drop, rewind;
    logic                   m_hs, out_eof, s2_ready, fetch, s1_valid;
    logic [RAM_W-1:0]       ram_dout;

    // run holds tready low until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run <= 1'b0;
        else     run <= 1'b1;
    end

    assign axis_s_tready = run && !(state == WR_IDLE && frames_stored == FRAMES_MAX);
    assign accept        = axis_s_tvalid && axis_s_tready;
    assign wr_ptr_inc    = wr_ptr + PTR_ONE;
    // rd_ptr retires words only once delivered, so one slot stays empty
    assign full          = (wr_ptr_inc[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        rewind    = 1'b0;
        case (state)
            WR_IDLE, WR_STORE: begin
                if (accept) begin
                    if (full) begin
                        rewind = 1'b1;
                        if (axis_s_tlast) begin
                            do_drop   = 1'b1;
                            state_nxt = WR_IDLE;
                        end else begin
                            state_nxt = WR_DROP;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (axis_s_tlast) begin
                            do_commit = 1'b1;
                            state_nxt = WR_IDLE;
                        end else begin
                            state_nxt = WR_STORE;
                        end
                    end
                end
            end
            WR_DROP: begin
                if (accept && axis_s_tlast) begin
                    do_drop   = 1'b1;
                    state_nxt = WR_IDLE;
                end
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WR_IDLE;
            wr_ptr        <= '0;
            wr_commit     <= '0;
            commit_q      <= '0;
            frames_stored <= '0;
            stat_drops    <= '0;
        end else begin
            state    <= state_nxt;
            commit_q <= wr_commit;
            if (rewind)     wr_ptr <= wr_commit;
            else if (wr_en) wr_ptr <= wr_ptr_inc;
            if (do_commit)  wr_commit <= wr_ptr_inc;
            if (do_commit && !out_eof)      frames_stored <= frames_stored + FRAME_ONE;
            else if (!do_commit && out_eof) frames_stored <= frames_stored - FRAME_ONE;
            if (do_drop && stat_drops != STAT_MAX) stat_drops <= stat_drops + STAT_ONE;
        end
    end

    aurora_tx_pktfifo_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (RAM_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (pack_word(axis_s_tlast, axis_s_tkeep, axis_s_tdata)),
        .rd_en   (fetch),
        .rd_addr (fetch_ptr[ADDR_W-1:0]),
        .rd_data (ram_dout)
    );

    // Two-stage read pipeline: RAM output register (s1) then output register.
    // Fetch is bounded by the delayed commit pointer, which also sets the
    // three-clock tlast-to-tvalid latency.
    assign m_hs     = axis_m_tvalid && axis_m_tready;
    assign out_eof  = m_hs && axis_m_tlast;
    assign s2_ready = !axis_m_tvalid || axis_m_tready;
    assign fetch    = (fetch_ptr != commit_q) && (!s1_valid || s2_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_ptr     <= '0;
            rd_ptr        <= '0;
            s1_valid      <= 1'b0;
            axis_m_tvalid <= 1'b0;
            axis_m_tdata  <= '0;
            axis_m_tkeep  <= '0;
            axis_m_tlast  <= 1'b0;
            stat_frames   <= '0;
        end else begin
            if (fetch)         fetch_ptr <= fetch_ptr + PTR_ONE;
            if (fetch)         s1_valid  <= 1'b1;
            else if (s2_ready) s1_valid  <= 1'b0;
            if (s2_ready) begin
                axis_m_tvalid <= s1_valid;
                if (s1_valid) begin
                    axis_m_tdata <= ram_dout[TKEEP_LSB-1:0];
                    axis_m_tkeep <= ram_dout[TKEEP_LSB +: 4];
                    axis_m_tlast <= ram_dout[TLAST_BIT];
                end
            end
            if (m_hs)    rd_ptr      <= rd_ptr + PTR_ONE;
            if (out_eof) stat_frames <= stat_frames + STAT_ONE;
        end
    end

    assign level = wr_commit - rd_ptr;

endmodule

// File: tb/tb_aurora_tx_pktfifo.sv
module tb_aurora_tx_pktfifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axis_s_tready;
    logic [31:0] axis_s_tdata = '0;
    logic [3:0]  axis_s_tkeep = '0;
    logic        axis_s_tvalid = 1'b0;
    logic        axis_s_tlast = 1'b0;
    logic        axis_m_tready = 1'b0;
    logic [31:0] axis_m_tdata;
    logic [3:0]  axis_m_tkeep;
    logic        axis_m_tvalid;
    logic        axis_m_tlast;
    logic [15:0] stat_frames;
    logic [15:0] stat_drops;
    logic [9:0]  level;

    int n_vec = 0;
    int n_err = 0;
    int exp_frames = 0;
    int exp_drops = 0;
    logic [36:0] rx_q[$];
    logic [36:0] exp_q[$];

    aurora_tx_pktfifo dut (
        .clk           (clk),
        .rst           (rst),
        .axis_s_tready (axis_s_tready),
        .axis_s_tdata  (axis_s_tdata),
        .axis_s_tkeep  (axis_s_tkeep),
        .axis_s_tvalid (axis_s_tvalid),
        .axis_s_tlast  (axis_s_tlast),
        .axis_m_tready (axis_m_tready),
        .axis_m_tdata  (axis_m_tdata),
        .axis_m_tkeep  (axis_m_tkeep),
        .axis_m_tvalid (axis_m_tvalid),
        .axis_m_tlast  (axis_m_tlast),
        .stat_frames   (stat_frames),
        .stat_drops    (stat_drops),
        .level         (level)
    );

    always #5 clk = ~clk;

    // beats that will complete a handshake at the next rising edge
    always @(negedge clk) begin
        if (!rst && axis_m_tvalid && axis_m_tready)
            rx_q.push_back({axis_m_tlast, axis_m_tkeep, axis_m_tdata});
    end

    task automatic send_frame(input int len, input logic [31:0] base,
                              input logic [3:0] last_keep, input bit keep_it,
                              output int stalls);
        bit acc;
        int g;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            axis_s_tvalid = 1'b1;
            axis_s_tdata  = base + 32'(i);
            axis_s_tlast  = (i == len - 1);
            axis_s_tkeep  = (i == len - 1) ? last_keep : 4'hF;
            acc = 1'b0;
            g = 0;
            while (!acc && g < 3000) begin
                @(negedge clk);
                acc = axis_s_tready;
                if (!acc) stalls++;
                @(posedge clk);
                #1;
                g++;
            end
            if (!acc) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout: beat %0d of %0d not accepted", i, len);
                break;
            end
            if (keep_it) exp_q.push_back({axis_s_tlast, axis_s_tkeep, axis_s_tdata});
        end
        axis_s_tvalid = 1'b0;
        axis_s_tlast  = 1'b0;
        if (keep_it) exp_frames++;
    endtask

    task automatic wait_rx(input int n);
        int g = 0;
        while (rx_q.size() < n && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (rx_q.size() < n) begin
            n_vec++; n_err++;
            $display("FAIL wait_rx: got %0d beats, expected %0d", rx_q.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (axis_s_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b expected 0", axis_s_tready); end
        n_vec++;
        if ({axis_m_tvalid, axis_m_tlast, axis_m_tkeep, axis_m_tdata} !== 38'd0) begin
            n_err++; $display("FAIL rst_m_out: got %b/%b/%h/%h expected all 0",
                              axis_m_tvalid, axis_m_tlast, axis_m_tkeep, axis_m_tdata);
        end
        n_vec++;
        if ({stat_frames, stat_drops, level} !== 42'd0) begin
            n_err++; $display("FAIL rst_stats: got %0d/%0d/%0d expected 0/0/0", stat_frames, stat_drops, level);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (axis_s_tready !== 1'b0) begin n_err++; $display("FAIL release_tready_early: got %b expected 0", axis_s_tready); end
        @(posedge clk);
        #1;
        n_vec++;
        if (axis_s_tready !== 1'b1) begin n_err++; $display("FAIL release_tready: got %b expected 1", axis_s_tready); end
    endtask

    task automatic test_lengths();
        int st, lat;
        logic [36:0] got;
        axis_m_tready = 1'b1;
        for (int len = 1; len <= 32; len++) begin
            send_frame(len, 32'd1, 4'hF, 1'b1, st);
            lat = 0;
            for (int k = 1; k <= 5; k++) begin
                @(posedge clk);
                #1;
                if (lat == 0 && axis_m_tvalid) lat = k;
            end
            n_vec++;
            if (lat != 3) begin n_err++; $display("FAIL latency len %0d: got %0d expected 3", len, lat); end
            wait_rx(len);
            n_vec++;
            if (rx_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL len_count len %0d: got %0d expected %0d", len, rx_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                got = '0;
                if (i < rx_q.size()) got = rx_q[i];
                n_vec++;
                if (got !== exp_q[i]) begin
                    n_err++; $display("FAIL len_data len %0d beat %0d: got %h expected %h", len, i, got, exp_q[i]);
                end
            end
            rx_q.delete();
            exp_q.delete();
        end
        n_vec++;
        if (stat_frames !== 16'd32) begin n_err++; $display("FAIL len_stat_frames: got %0d expected 32", stat_frames); end
        n_vec++;
        if (stat_drops !== 16'd0) begin n_err++; $display("FAIL len_stat_drops: got %0d expected 0", stat_drops); end
    endtask

    task automatic test_last_keep();
        int st;
        logic [36:0] got;
        send_frame(1, 32'h1111_1111, 4'hF, 1'b0, st);
        send_frame(1, 32'hA1B2_C3D4, 4'h3, 1'b0, st);
        exp_q.push_back({1'b1, 4'hF, 32'h1111_1111});
        exp_q.push_back({1'b1, 4'h3, 32'hA1B2_C3D4});
        exp_frames += 2;
        wait_rx(2);
        foreach (exp_q[i]) begin
            got = '0;
            if (i < rx_q.size()) got = rx_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++; $display("FAIL last_keep beat %0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int st, seen;
        logic [36:0] got;
        axis_m_tready = 1'b0;
        for (int f = 0; f < 31; f++) send_frame(4, 32'h3000_0000 + 32'(f * 256), 4'hF, 1'b1, st);
        n_vec++;
        if (level !== 10'd124) begin n_err++; $display("FAIL bp_level: got %0d expected 124", level); end
        n_vec++;
        if (axis_m_tvalid !== 1'b1 || axis_m_tdata !== 32'h3000_0000) begin
            n_err++; $display("FAIL bp_head: got %b/%h expected 1/30000000", axis_m_tvalid, axis_m_tdata);
        end
        axis_s_tvalid = 1'b1;
        axis_s_tdata  = 32'h3000_1F00;
        axis_s_tkeep  = 4'hF;
        axis_s_tlast  = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (axis_s_tready) seen++;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL bp_full_tready: got %0d ready cycles expected 0", seen); end
        n_vec++;
        if (axis_m_tdata !== 32'h3000_0000) begin n_err++; $display("FAIL bp_hold: got %h expected 30000000", axis_m_tdata); end
        axis_m_tready = 1'b1;
        send_frame(4, 32'h3000_1F00, 4'hF, 1'b1, st);
        n_vec++;
        if (st != 4) begin n_err++; $display("FAIL bp_stalls: got %0d expected 4", st); end
        wait_rx(128);
        n_vec++;
        if (rx_q.size() != 128) begin n_err++; $display("FAIL bp_count: got %0d expected 128", rx_q.size()); end
        foreach (exp_q[i]) begin
            got = '0;
            if (i < rx_q.size()) got = rx_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++; $display("FAIL bp_data beat %0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
        n_vec++;
        if (stat_frames !== 16'(exp_frames)) begin n_err++; $display("FAIL bp_stat_frames: got %0d expected %0d", stat_frames, exp_frames); end
        n_vec++;
        if (level !== 10'd0) begin n_err++; $display("FAIL bp_level_end: got %0d expected 0", level); end
    endtask

    task automatic test_overflow();
        int st;
        logic [36:0] got;
        axis_m_tready = 1'b0;
        send_frame(4, 32'h4000_0000, 4'hF, 1'b1, st);
        n_vec++;
        if (level !== 10'd4) begin n_err++; $display("FAIL ovf_level_pre: got %0d expected 4", level); end
        send_frame(600, 32'h4100_0000, 4'hF, 1'b0, st);
        exp_drops++;
        n_vec++;
        if (st != 0) begin n_err++; $display("FAIL ovf_tready: got %0d stalls expected 0", st); end
        n_vec++;
        if (stat_drops !== 16'(exp_drops)) begin n_err++; $display("FAIL ovf_drops: got %0d expected %0d", stat_drops, exp_drops); end
        n_vec++;
        if (level !== 10'd4) begin n_err++; $display("FAIL ovf_level_post: got %0d expected 4", level); end
        axis_m_tready = 1'b1;
        send_frame(4, 32'h4200_0000, 4'hF, 1'b1, st);
        wait_rx(8);
        n_vec++;
        if (rx_q.size() != 8) begin n_err++; $display("FAIL ovf_count: got %0d expected 8", rx_q.size()); end
        foreach (exp_q[i]) begin
            got = '0;
            if (i < rx_q.size()) got = rx_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++; $display("FAIL ovf_data beat %0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
        n_vec++;
        if (level !== 10'd0) begin n_err++; $display("FAIL ovf_level_end: got %0d expected 0", level); end
    endtask

    task automatic test_back_to_back();
        int st;
        bit done;
        int g;
        logic [36:0] got;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 40; f++)
                    send_frame((f % 2) + 1, 32'h5000_0000 + 32'(f * 16), 4'hF, 1'b1, st);
                done = 1'b1;
            end
            begin
                g = 0;
                while (!(done && rx_q.size() >= exp_q.size()) && g < 5000) begin
                    @(posedge clk);
                    #1;
                    axis_m_tready = 1'($urandom_range(0, 1));
                    g++;
                end
                axis_m_tready = 1'b1;
            end
        join
        wait_rx(60);
        n_vec++;
        if (rx_q.size() != 60) begin n_err++; $display("FAIL b2b_count: got %0d expected 60", rx_q.size()); end
        foreach (exp_q[i]) begin
            got = '0;
            if (i < rx_q.size()) got = rx_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++; $display("FAIL b2b_data beat %0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
        n_vec++;
        if (stat_frames !== 16'(exp_frames)) begin n_err++; $display("FAIL b2b_stat_frames: got %0d expected %0d", stat_frames, exp_frames); end
        n_vec++;
        if (level !== 10'd0 || axis_s_tready !== 1'b1) begin
            n_err++; $display("FAIL b2b_idle: got level %0d tready %b expected 0/1", level, axis_s_tready);
        end
    endtask

    task automatic test_reset_midframe();
        int st;
        logic [36:0] got;
        axis_m_tready = 1'b1;
        send_frame(4, 32'h7000_0000, 4'hF, 1'b0, st);
        for (int i = 0; i < 5; i++) begin
            axis_s_tvalid = 1'b1;
            axis_s_tdata  = 32'h7100_0000 + 32'(i);
            axis_s_tkeep  = 4'hF;
            axis_s_tlast  = 1'b0;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (axis_m_tvalid !== 1'b1) begin n_err++; $display("FAIL mid_out_active: got %b expected 1", axis_m_tvalid); end
        rst = 1'b1;
        axis_s_tvalid = 1'b0;
        #1;
        n_vec++;
        if ({axis_m_tvalid, axis_m_tlast, axis_m_tkeep, axis_m_tdata} !== 38'd0) begin
            n_err++; $display("FAIL mid_rst_out: got %b/%b/%h/%h expected all 0",
                              axis_m_tvalid, axis_m_tlast, axis_m_tkeep, axis_m_tdata);
        end
        n_vec++;
        if (axis_s_tready !== 1'b0) begin n_err++; $display("FAIL mid_rst_tready: got %b expected 0", axis_s_tready); end
        n_vec++;
        if ({stat_frames, stat_drops, level} !== 42'd0) begin
            n_err++; $display("FAIL mid_rst_stats: got %0d/%0d/%0d expected 0/0/0", stat_frames, stat_drops, level);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rx_q.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_drops = 0;
        send_frame(3, 32'h8000_0000, 4'hF, 1'b1, st);
        wait_rx(3);
        n_vec++;
        if (rx_q.size() != 3) begin n_err++; $display("FAIL post_rst_count: got %0d expected 3", rx_q.size()); end
        foreach (exp_q[i]) begin
            got = '0;
            if (i < rx_q.size()) got = rx_q[i];
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++; $display("FAIL post_rst_data beat %0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
        n_vec++;
        if (stat_frames !== 16'd1 || stat_drops !== 16'd0) begin
            n_err++; $display("FAIL post_rst_stats: got %0d/%0d expected 1/0", stat_frames, stat_drops);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_lengths();
        test_last_keep();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
